// File: rtl/relu_maxpool.sv
// ---------------------------------------------------------------------------
// relu_maxpool
//
// Streams a signed 32-bit convolution map (M x M samples, raster order),
// applies ReLU plus requantisation to 16 bits, and performs a 2x2 max-pool
// with stride 2. One pooled activation leaves per 2x2 window.
//
// Horizontal pairs are reduced on the fly through a pair register. Even map
// rows park their pair maxima in a half-width line buffer. Odd map rows
// combine their pair maxima with the parked value to produce the output.
//
// Ports
//   clk         in   1  rising-edge clock for all state
//   global_rst  in   1  synchronous active-high reset (works even with ce=0)
//   ce          in   1  clock enable; ce=0 freezes all state and outputs
//   conv_op     in  32  signed convolution sample
//   valid_conv  in   1  conv_op is valid this cycle
//   end_conv    in   1  upstream finished; forces DONE
//   pool_op     out 16  pooled activation; holds its value between pulses
//   valid_pool  out  1  one-cycle pulse per pooled activation
//   end_pool    out  1  pooling finished; sticky until reset
// ---------------------------------------------------------------------------
module relu_maxpool #(
    parameter int M     = 8,
    parameter int SHIFT = 8
) (
    input  logic        clk,
    input  logic        global_rst,
    input  logic        ce,
    input  logic [31:0] conv_op,
    input  logic        valid_conv,
    input  logic        end_conv,
    output logic [15:0] pool_op,
    output logic        valid_pool,
    output logic        end_pool
);

    localparam int CW   = $clog2(M);
    localparam int HALF = M / 2;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    // Rounded up to a power of two so every index value addresses a real entry.
    localparam int LB_DEPTH = 1 << BW;

    localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(M - 1);

    localparam logic [1:0] ST_EVEN_ROW = 2'd0;
    localparam logic [1:0] ST_ODD_ROW  = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    // ReLU followed by arithmetic right shift and saturation to 16 bits.
    // Negative inputs go to zero, so the shift only ever sees values >= 0.
    function automatic logic [15:0] requant(input logic [31:0] acc);
        logic [31:0] sh;
        sh = acc >> SHIFT;
        if (acc[31]) begin
            requant = 16'h0000;
        end else if (sh > 32'h0000_7FFF) begin
            requant = 16'h7FFF;
        end else begin
            requant = sh[15:0];
        end
    endfunction

    // Unsigned maximum of two activations.
    function automatic logic [15:0] umax(input logic [15:0] a, input logic [15:0] b);
        umax = (a > b) ? a : b;
    endfunction

    // State registers and their next-state values
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [15:0]   pair_q, pair_d;
    logic [15:0]   pool_q, pool_d;
    logic          valid_q, valid_d;
    logic          end_q, end_d;

    logic [15:0]   lbuf_q [LB_DEPTH];

    // Combinational helpers
    logic          consume_s;
    logic          col_last_s;
    logic          row_last_s;
    logic          odd_col_s;
    logic [15:0]   r_s;
    logic [15:0]   h_s;
    logic [BW-1:0] lb_idx_s;
    logic [15:0]   lb_rd_s;
    logic          lb_we_s;

    // Per-sample datapath: requantised value, pair maximum, buffer read.
    always_comb begin
        consume_s  = ce && valid_conv && (state_q != ST_DONE);
        col_last_s = (col_q == COL_LAST);
        row_last_s = (row_q == ROW_LAST);
        odd_col_s  = col_q[0];
        r_s        = requant(conv_op);
        h_s        = umax(pair_q, r_s);
        lb_idx_s   = BW'(col_q >> 1);
        lb_rd_s    = lbuf_q[lb_idx_s];
    end

    // Next-state logic for counters, FSM, pair register and outputs.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        pool_d  = pool_q;
        valid_d = valid_q;
        end_d   = end_q;
        lb_we_s = 1'b0;

        if (ce) begin
            // The pulse lasts exactly one enabled cycle.
            valid_d = 1'b0;

            if (consume_s) begin
                if (col_last_s) begin
                    col_d = {CW{1'b0}};
                    if (row_last_s) begin
                        row_d = {CW{1'b0}};
                    end else begin
                        row_d = row_q + CW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                    row_d = row_q;
                end

                if (!odd_col_s) begin
                    pair_d = r_s;
                end else begin
                    pair_d = pair_q;
                end

                case (state_q)
                    ST_EVEN_ROW: begin
                        if (odd_col_s) begin
                            lb_we_s = 1'b1;
                        end else begin
                            lb_we_s = 1'b0;
                        end
                        if (col_last_s) begin
                            state_d = ST_ODD_ROW;
                        end else begin
                            state_d = ST_EVEN_ROW;
                        end
                    end
                    ST_ODD_ROW: begin
                        if (odd_col_s) begin
                            pool_d  = umax(h_s, lb_rd_s);
                            valid_d = 1'b1;
                        end else begin
                            pool_d  = pool_q;
                        end
                        if (col_last_s) begin
                            if (row_last_s) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_EVEN_ROW;
                            end
                        end else begin
                            state_d = ST_ODD_ROW;
                        end
                    end
                    default: begin
                        // Unreachable encoding: park safely until reset.
                        state_d = ST_DONE;
                    end
                endcase
            end else begin
                state_d = state_q;
            end

            // Early termination still lets a same-cycle final output through,
            // because the datapath above has already been evaluated.
            if (end_conv && (state_q != ST_DONE)) begin
                state_d = ST_DONE;
            end else begin
                state_d = state_d;
            end

            end_d = (state_d == ST_DONE);
        end else begin
            valid_d = valid_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q <= ST_EVEN_ROW;
            col_q   <= {CW{1'b0}};
            row_q   <= {CW{1'b0}};
            pair_q  <= 16'h0000;
            pool_q  <= 16'h0000;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            pool_q  <= pool_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    // Line buffer of even-row pair maxima; always written before it is read.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            lbuf_q[lb_idx_s] <= h_s;
        end
    end

    assign pool_op    = pool_q;
    assign valid_pool = valid_q;
    assign end_pool   = end_q;

endmodule

// File: tb/tb_relu_maxpool.sv
module tb_relu_maxpool;

    logic        clk = 1'b0;
    logic        global_rst;
    logic        ce;
    logic [31:0] conv_op;
    logic        valid_conv;
    logic        end_conv;
    logic [15:0] pool_op;
    logic        valid_pool;
    logic        end_pool;

    logic [31:0] conv8;
    logic        valid8;
    logic        end8;
    logic [15:0] pool8;
    logic        vpool8;
    logic        epool8;

    relu_maxpool #(.M(4), .SHIFT(0)) dut (
        .clk(clk), .global_rst(global_rst), .ce(ce), .conv_op(conv_op),
        .valid_conv(valid_conv), .end_conv(end_conv), .pool_op(pool_op),
        .valid_pool(valid_pool), .end_pool(end_pool)
    );

    relu_maxpool #(.M(2), .SHIFT(8)) dut8 (
        .clk(clk), .global_rst(global_rst), .ce(ce), .conv_op(conv8),
        .valid_conv(valid8), .end_conv(end8), .pool_op(pool8),
        .valid_pool(vpool8), .end_pool(epool8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          emits;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] val;
        longint      due;
    } sb_t;

    vec_t map_a[16];
    vec_t map_neg[16];
    vec_t map_sat[16];
    vec_t cur[16];
    sb_t  sb[$];
    sb_t  mon_s;
    sb_t  drv_s;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      edges   = 0;
    logic        ce_prev = 1'b0;
    logic        rst_prev = 1'b1;
    bit          mon_en = 1'b0;
    logic [15:0] last_pool = 16'h0000;
    logic        last_valid = 1'b0;
    logic [31:0] d8[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        edges    <= edges + 1;
        ce_prev  <= ce;
        rst_prev <= global_rst;
    end

    // Scoreboard monitor: new pulses follow an enabled edge; otherwise outputs hold.
    always @(negedge clk) begin
        if (mon_en && !rst_prev) begin
            if (!ce_prev) begin
                check("ce_hold_valid", 32'(valid_pool), 32'(last_valid));
            end
            if (valid_pool && ce_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(pool_op), 32'hFFFF_FFFF);
                end else begin
                    mon_s = sb.pop_front();
                    check("pool_value", 32'(pool_op), 32'(mon_s.val));
                    check("pool_latency", 32'(edges), 32'(mon_s.due));
                end
            end else begin
                check("pool_hold", 32'(pool_op), 32'(last_pool));
            end
        end
        last_pool  = pool_op;
        last_valid = valid_pool;
    end

    task automatic do_reset(input bit chk);
        global_rst = 1'b1;
        ce         = 1'b0;
        valid_conv = 1'b0;
        end_conv   = 1'b0;
        valid8     = 1'b0;
        tick();
        global_rst = 1'b0;
        ce         = 1'b1;
        if (chk) begin
            check("rst_pool_op", 32'(pool_op), 32'h0);
            check("rst_valid", 32'(valid_pool), 32'h0);
            check("rst_end", 32'(end_pool), 32'h0);
        end
    endtask

    task automatic run_map(input int n, input bit stall, input bit push, input bit end_last);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                for (int j = 0; j < (i + 1) % 3; j++) begin
                    conv_op = 32'h7FFF_0000;
                    if (((i + j) % 2) == 0) begin
                        ce = 1'b0;
                        valid_conv = 1'b1;
                    end else begin
                        ce = 1'b1;
                        valid_conv = 1'b0;
                    end
                    tick();
                end
            end
            ce         = 1'b1;
            valid_conv = 1'b1;
            conv_op    = cur[i].data;
            end_conv   = end_last && (i == n - 1);
            if (push && cur[i].emits) begin
                drv_s.val = cur[i].exp;
                drv_s.due = edges + 1;
                sb.push_back(drv_s);
            end
            tick();
            valid_conv = 1'b0;
            end_conv   = 1'b0;
            conv_op    = 32'hDEAD_BEEF;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
        check("queue_drained", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int          rows_a[16];
        logic [15:0] exp_a[4];
        logic [15:0] exp_s[4];
        int          k;

        rows_a = '{1, 5, 3, 2, 4, 0, 7, 9, 2, 2, 2, 2, 8, 1, 1, 6};
        exp_a  = '{16'd5, 16'd9, 16'd8, 16'd6};
        exp_s  = '{16'h7FFF, 16'd9, 16'd8, 16'd6};
        k = 0;
        for (int i = 0; i < 16; i++) begin
            map_a[i].data    = 32'(rows_a[i]);
            map_a[i].emits   = (((i / 4) % 2) == 1) && ((i % 2) == 1);
            map_a[i].exp     = 16'h0;
            map_neg[i].data  = 32'hFFFF_FF9C;
            map_neg[i].emits = map_a[i].emits;
            map_neg[i].exp   = 16'h0;
            if (map_a[i].emits) begin
                map_a[i].exp = exp_a[k];
                k++;
            end
        end
        map_sat = map_a;
        map_sat[0].data = 32'h0001_0000;
        map_sat[2].data = 32'h8000_0000;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (map_sat[i].emits) begin
                map_sat[i].exp = exp_s[k];
                k++;
            end
        end
        d8 = '{32'h0000_1234, 32'h0000_0F00, 32'h0000_0100, 32'h8000_0000};

        global_rst = 1'b1; ce = 1'b0; valid_conv = 1'b0; end_conv = 1'b0;
        conv_op = 32'h0; conv8 = 32'h0; valid8 = 1'b0; end8 = 1'b0;
        tick();
        do_reset(1'b1);
        mon_en = 1'b1;

        // Clean map, then samples in DONE must be ignored
        cur = map_a;
        run_map(16, 1'b0, 1'b1, 1'b0);
        drain();
        check("end_after_map", 32'(end_pool), 32'h1);
        run_map(8, 1'b0, 1'b0, 1'b0);
        drain();
        check("end_sticky", 32'(end_pool), 32'h1);

        // Reset with ce low clears sticky end and pool_op
        do_reset(1'b1);

        // Same map with bubbles and ce stalls
        run_map(16, 1'b1, 1'b1, 1'b0);
        drain();
        check("end_after_stall_map", 32'(end_pool), 32'h1);

        // All-negative map
        do_reset(1'b0);
        cur = map_neg;
        run_map(16, 1'b0, 1'b1, 1'b0);
        drain();

        // Saturation and large negative
        do_reset(1'b0);
        cur = map_sat;
        run_map(16, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset in the middle of row 1, then a full map
        do_reset(1'b0);
        cur = map_a;
        run_map(5, 1'b0, 1'b1, 1'b0);
        do_reset(1'b1);
        run_map(16, 1'b0, 1'b1, 1'b0);
        drain();

        // end_conv after row 1
        do_reset(1'b0);
        run_map(8, 1'b0, 1'b1, 1'b0);
        drain();
        check("end_before_endconv", 32'(end_pool), 32'h0);
        end_conv = 1'b1;
        ce = 1'b1;
        tick();
        end_conv = 1'b0;
        check("end_after_endconv", 32'(end_pool), 32'h1);
        run_map(8, 1'b0, 1'b0, 1'b0);
        drain();

        // end_conv together with the final due sample: output still emitted
        do_reset(1'b0);
        run_map(8, 1'b0, 1'b1, 1'b1);
        check("end_same_cycle", 32'(end_pool), 32'h1);
        drain();

        // SHIFT=8, 2x2 map on the second instance
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            conv8  = d8[i];
            valid8 = 1'b1;
            ce     = 1'b1;
            tick();
            if (i < 3) check("s8_no_pulse", 32'(vpool8), 32'h0);
        end
        valid8 = 1'b0;
        check("s8_valid", 32'(vpool8), 32'h1);
        check("s8_value", 32'(pool8), 32'h0012);
        check("s8_end", 32'(epool8), 32'h1);
        tick();
        check("s8_pulse_clears", 32'(vpool8), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
